// File: rtl/oup_sm_ulpi_syncmode_rx_pkg.sv
// Shared types for the ULPI synchronous-mode receive path: FSM states, RX CMD layout and decoder.
package oup_sm_ulpi_syncmode_rx_p;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StTurn     = 3'd1,
    StRx       = 3'd2,
    StRegrTurn = 3'd3,
    StRegrData = 3'd4
  } rx_states_t;

  typedef enum logic [1:0] {
    EvNone       = 2'b00,
    EvActive     = 2'b01,
    EvDisconnect = 2'b10,
    EvError      = 2'b11
  } rx_event_t;

  typedef struct packed {
    logic      alt_int;
    logic      id;
    rx_event_t rx_event;
    logic [1:0] vbus_state;
    logic [1:0] linestate;
  } rxcmd_t;

  function automatic rxcmd_t decode_rxcmd(input logic [7:0] byte_i);
    rxcmd_t cmd;
    cmd.alt_int    = byte_i[7];
    cmd.id         = byte_i[6];
    cmd.rx_event   = rx_event_t'(byte_i[5:4]);
    cmd.vbus_state = byte_i[3:2];
    cmd.linestate  = byte_i[1:0];
    return cmd;
  endfunction

endpackage

// File: rtl/oup_sm_ulpi_syncmode_rx.sv
// ULPI synchronous-mode receive FSM: handles PHY-driven bus cycles (USB data, RX CMDs) and
// register-read turnarounds on behalf of the TX machine. All outputs are registered.
module oup_sm_ulpi_syncmode_rx
  import oup_sm_ulpi_syncmode_rx_p::*;
(
  input  logic       ulpi_clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ulpi_data_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic       rx_regr_assert_i,
  output logic       rx_done_o,
  output logic       rx_abort_o,
  output logic [7:0] phyreg_o,
  output logic [7:0] rx_data_o,
  output logic       rx_data_valid_o,
  input  logic       rx_data_full_i,
  output logic       rx_overflow_o,
  output logic [7:0] rxcmd_o,
  output logic       rxcmd_valid_o,
  output logic [1:0] linestate_o,
  output logic [1:0] vbus_state_o,
  output logic       id_o,
  output logic       rx_active_o,
  output logic       rx_error_o,
  output logic       host_disconnect_o,
  output logic       rx_end_o
);

  rx_states_t state_q, state_d;
  logic       dir_q;

  logic       rx_done_q, rx_done_d;
  logic       rx_abort_q, rx_abort_d;
  logic [7:0] phyreg_q, phyreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_data_valid_q, rx_data_valid_d;
  logic       rx_overflow_q, rx_overflow_d;
  logic [7:0] rxcmd_q, rxcmd_d;
  logic       rxcmd_valid_q, rxcmd_valid_d;
  logic [1:0] linestate_q, linestate_d;
  logic [1:0] vbus_state_q, vbus_state_d;
  logic       id_q, id_d;
  logic       rx_active_q, rx_active_d;
  logic       rx_error_q, rx_error_d;
  logic       host_disconnect_q, host_disconnect_d;
  logic       rx_end_q, rx_end_d;

  logic       take_data;
  logic       take_rxcmd;
  rxcmd_t     cmd;
  logic       unused_alt_int;

  assign cmd            = decode_rxcmd(ulpi_data_i);
  assign unused_alt_int = cmd.alt_int;

  always_comb begin
    state_d           = state_q;
    take_data         = 1'b0;
    take_rxcmd        = 1'b0;
    rx_done_d         = 1'b0;
    rx_abort_d        = 1'b0;
    rx_data_valid_d   = 1'b0;
    rx_overflow_d     = 1'b0;
    rxcmd_valid_d     = 1'b0;
    rx_end_d          = 1'b0;
    phyreg_d          = phyreg_q;
    rx_data_d         = rx_data_q;
    rxcmd_d           = rxcmd_q;
    linestate_d       = linestate_q;
    vbus_state_d      = vbus_state_q;
    id_d              = id_q;
    rx_active_d       = rx_active_q;
    rx_error_d        = rx_error_q;
    host_disconnect_d = host_disconnect_q;

    case (state_q)
      StIdle: begin
        // The read request is sampled only on the edge where dir rises.
        if (ulpi_dir_i && !dir_q) begin
          state_d = rx_regr_assert_i ? StRegrTurn : StTurn;
        end
      end
      StTurn: begin
        state_d = ulpi_dir_i ? StRx : StIdle;
      end
      StRx: begin
        if (!ulpi_dir_i) begin
          state_d = StIdle;
          if (rx_active_q) begin
            rx_end_d    = 1'b1;
            rx_active_d = 1'b0;
            rx_error_d  = 1'b0;
          end
        end else if (ulpi_nxt_i) begin
          take_data = 1'b1;
        end else begin
          take_rxcmd = 1'b1;
        end
      end
      StRegrTurn: begin
        if (!ulpi_dir_i) begin
          rx_abort_d = 1'b1;
          state_d    = StIdle;
        end else if (ulpi_nxt_i) begin
          // PHY grabbed the bus for a USB receive instead of returning register data.
          rx_abort_d  = 1'b1;
          rx_active_d = 1'b1;
          state_d     = StRx;
        end else begin
          state_d = StRegrData;
        end
      end
      StRegrData: begin
        if (!ulpi_dir_i) begin
          rx_abort_d = 1'b1;
          state_d    = StIdle;
        end else if (ulpi_nxt_i) begin
          rx_abort_d = 1'b1;
          take_data  = 1'b1;
          state_d    = StRx;
        end else begin
          phyreg_d  = ulpi_data_i;
          rx_done_d = 1'b1;
          state_d   = StRx;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (take_data) begin
      if (rx_data_full_i) begin
        rx_overflow_d = 1'b1;
      end else begin
        rx_data_d       = ulpi_data_i;
        rx_data_valid_d = 1'b1;
      end
    end

    if (take_rxcmd) begin
      rxcmd_d           = ulpi_data_i;
      rxcmd_valid_d     = 1'b1;
      linestate_d       = cmd.linestate;
      vbus_state_d      = cmd.vbus_state;
      id_d              = cmd.id;
      host_disconnect_d = (cmd.rx_event == EvDisconnect);
      unique case (cmd.rx_event)
        EvNone: begin
          rx_active_d = 1'b0;
          rx_error_d  = 1'b0;
        end
        EvActive: begin
          rx_active_d = 1'b1;
        end
        EvError: begin
          rx_active_d = 1'b1;
          rx_error_d  = 1'b1;
        end
        EvDisconnect: begin
        end
      endcase
    end
  end

  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      dir_q             <= 1'b0;
      rx_done_q         <= 1'b0;
      rx_abort_q        <= 1'b0;
      phyreg_q          <= 8'h00;
      rx_data_q         <= 8'h00;
      rx_data_valid_q   <= 1'b0;
      rx_overflow_q     <= 1'b0;
      rxcmd_q           <= 8'h00;
      rxcmd_valid_q     <= 1'b0;
      linestate_q       <= 2'b00;
      vbus_state_q      <= 2'b00;
      id_q              <= 1'b0;
      rx_active_q       <= 1'b0;
      rx_error_q        <= 1'b0;
      host_disconnect_q <= 1'b0;
      rx_end_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      dir_q             <= ulpi_dir_i;
      rx_done_q         <= rx_done_d;
      rx_abort_q        <= rx_abort_d;
      phyreg_q          <= phyreg_d;
      rx_data_q         <= rx_data_d;
      rx_data_valid_q   <= rx_data_valid_d;
      rx_overflow_q     <= rx_overflow_d;
      rxcmd_q           <= rxcmd_d;
      rxcmd_valid_q     <= rxcmd_valid_d;
      linestate_q       <= linestate_d;
      vbus_state_q      <= vbus_state_d;
      id_q              <= id_d;
      rx_active_q       <= rx_active_d;
      rx_error_q        <= rx_error_d;
      host_disconnect_q <= host_disconnect_d;
      rx_end_q          <= rx_end_d;
    end
  end

  assign rx_done_o         = rx_done_q;
  assign rx_abort_o        = rx_abort_q;
  assign phyreg_o          = phyreg_q;
  assign rx_data_o         = rx_data_q;
  assign rx_data_valid_o   = rx_data_valid_q;
  assign rx_overflow_o     = rx_overflow_q;
  assign rxcmd_o           = rxcmd_q;
  assign rxcmd_valid_o     = rxcmd_valid_q;
  assign linestate_o       = linestate_q;
  assign vbus_state_o      = vbus_state_q;
  assign id_o              = id_q;
  assign rx_active_o       = rx_active_q;
  assign rx_error_o        = rx_error_q;
  assign host_disconnect_o = host_disconnect_q;
  assign rx_end_o          = rx_end_q;

endmodule

// File: tb/tb_oup_sm_ulpi_syncmode_rx.sv
// Bench for the ULPI receive FSM: directed scenarios plus random bus traffic, all checked
// against a cycle-level reference model built from the bus-ownership rules.
module tb_oup_sm_ulpi_syncmode_rx;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       dir;
  logic       nxt;
  logic       regr;
  logic       full;

  logic       rx_done, rx_abort, rx_data_valid, rx_overflow, rxcmd_valid;
  logic       id, rx_active, rx_error, host_disc, rx_end;
  logic [7:0] phyreg, rx_data, rxcmd;
  logic [1:0] linestate, vbus_state;

  int total;
  int bad;

  oup_sm_ulpi_syncmode_rx dut (
    .ulpi_clk_i        (clk),
    .rst_ni            (rst_n),
    .ulpi_data_i       (data),
    .ulpi_dir_i        (dir),
    .ulpi_nxt_i        (nxt),
    .rx_regr_assert_i  (regr),
    .rx_done_o         (rx_done),
    .rx_abort_o        (rx_abort),
    .phyreg_o          (phyreg),
    .rx_data_o         (rx_data),
    .rx_data_valid_o   (rx_data_valid),
    .rx_data_full_i    (full),
    .rx_overflow_o     (rx_overflow),
    .rxcmd_o           (rxcmd),
    .rxcmd_valid_o     (rxcmd_valid),
    .linestate_o       (linestate),
    .vbus_state_o      (vbus_state),
    .id_o              (id),
    .rx_active_o       (rx_active),
    .rx_error_o        (rx_error),
    .host_disconnect_o (host_disc),
    .rx_end_o          (rx_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bus ownership, whether the turnaround beat has passed, read outstanding.
  bit         m_owned, m_turned, m_reading, m_pdir;
  bit         m_done, m_abort, m_valid, m_ovf, m_cmdv, m_end;
  bit         m_id, m_active, m_error, m_disc;
  bit [7:0]   m_phyreg, m_rxdata, m_rxcmd;
  bit [1:0]   m_ls, m_vbus;

  task automatic model_reset();
    m_owned = 0; m_turned = 0; m_reading = 0; m_pdir = 0;
    m_done = 0; m_abort = 0; m_valid = 0; m_ovf = 0; m_cmdv = 0; m_end = 0;
    m_id = 0; m_active = 0; m_error = 0; m_disc = 0;
    m_phyreg = 0; m_rxdata = 0; m_rxcmd = 0; m_ls = 0; m_vbus = 0;
  endtask

  task automatic model_byte();
    if (full) m_ovf = 1;
    else begin
      m_valid  = 1;
      m_rxdata = data;
    end
  endtask

  task automatic model_rxcmd();
    int ev;
    ev      = (data >> 4) % 4;
    m_cmdv  = 1;
    m_rxcmd = data;
    m_ls    = 2'(data % 4);
    m_vbus  = 2'((data >> 2) % 4);
    m_id    = data[6];
    m_disc  = (ev == 2);
    if (ev == 0) begin m_active = 0; m_error = 0; end
    if (ev == 1) m_active = 1;
    if (ev == 3) begin m_active = 1; m_error = 1; end
  endtask

  task automatic model_clock();
    m_done = 0; m_abort = 0; m_valid = 0; m_ovf = 0; m_cmdv = 0; m_end = 0;
    if (!m_owned) begin
      if (dir && !m_pdir) begin
        m_owned = 1; m_turned = 0; m_reading = regr;
      end
    end else if (!m_turned) begin
      if (!dir) begin
        m_owned = 0;
        if (m_reading) m_abort = 1;
        m_reading = 0;
      end else begin
        m_turned = 1;
        if (m_reading && nxt) begin
          m_abort = 1; m_active = 1; m_reading = 0;
        end
      end
    end else if (m_reading) begin
      m_reading = 0;
      if (!dir) begin
        m_abort = 1; m_owned = 0;
      end else if (nxt) begin
        m_abort = 1;
        model_byte();
      end else begin
        m_phyreg = data; m_done = 1;
      end
    end else begin
      if (!dir) begin
        m_owned = 0;
        if (m_active) begin
          m_end = 1; m_active = 0; m_error = 0;
        end
      end else if (nxt) model_byte();
      else model_rxcmd();
    end
    m_pdir = dir;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("rx_done", {7'd0, rx_done}, {7'd0, m_done});
    check("rx_abort", {7'd0, rx_abort}, {7'd0, m_abort});
    check("phyreg", phyreg, m_phyreg);
    check("rx_data", rx_data, m_rxdata);
    check("rx_data_valid", {7'd0, rx_data_valid}, {7'd0, m_valid});
    check("rx_overflow", {7'd0, rx_overflow}, {7'd0, m_ovf});
    check("rxcmd", rxcmd, m_rxcmd);
    check("rxcmd_valid", {7'd0, rxcmd_valid}, {7'd0, m_cmdv});
    check("linestate", {6'd0, linestate}, {6'd0, m_ls});
    check("vbus_state", {6'd0, vbus_state}, {6'd0, m_vbus});
    check("id", {7'd0, id}, {7'd0, m_id});
    check("rx_active", {7'd0, rx_active}, {7'd0, m_active});
    check("rx_error", {7'd0, rx_error}, {7'd0, m_error});
    check("host_disconnect", {7'd0, host_disc}, {7'd0, m_disc});
    check("rx_end", {7'd0, rx_end}, {7'd0, m_end});
    check("done_abort_excl", {7'd0, rx_done & rx_abort}, 8'd0);
  endtask

  // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
  task automatic step(input logic d, input logic n, input logic [7:0] b, input logic r,
                      input logic f);
    dir = d; nxt = n; data = b; regr = r; full = f;
    model_clock();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dir = 0; nxt = 0; data = 0; regr = 0; full = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    step(0, 0, 8'h00, 0, 0);

    // Successful register read
    step(0, 0, 8'h00, 1, 0);
    step(1, 0, 8'hFF, 1, 0);
    step(1, 0, 8'hEE, 1, 0);
    step(1, 0, 8'h5A, 1, 0);
    check("read_phyreg", phyreg, 8'h5A);
    check("read_done", {7'd0, rx_done}, 8'd1);
    check("read_no_abort", {7'd0, rx_abort}, 8'd0);
    step(0, 0, 8'h00, 0, 0);
    check("read_done_one_pulse", {7'd0, rx_done}, 8'd0);

    // Read pre-empted by USB receive
    step(1, 1, 8'h00, 1, 0);
    step(1, 1, 8'h00, 1, 0);
    check("preempt_abort", {7'd0, rx_abort}, 8'd1);
    check("preempt_active", {7'd0, rx_active}, 8'd1);
    step(1, 1, 8'hC3, 0, 0);
    check("preempt_byte0", rx_data, 8'hC3);
    step(1, 1, 8'h11, 0, 0);
    check("preempt_byte1", rx_data, 8'h11);
    check("preempt_phyreg_kept", phyreg, 8'h5A);
    step(0, 0, 8'h00, 0, 0);
    check("preempt_end", {7'd0, rx_end}, 8'd1);

    // RX CMDs: error event then active event, then turnaround back
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h7D, 0, 0);
    step(1, 0, 8'h5D, 0, 0);
    check("cmd_linestate", {6'd0, linestate}, 8'h01);
    check("cmd_vbus", {6'd0, vbus_state}, 8'h03);
    check("cmd_id", {7'd0, id}, 8'd1);
    check("cmd_active", {7'd0, rx_active}, 8'd1);
    check("cmd_error", {7'd0, rx_error}, 8'd1);
    step(0, 0, 8'h00, 0, 0);
    check("cmd_end", {7'd0, rx_end}, 8'd1);
    check("cmd_active_clr", {7'd0, rx_active}, 8'd0);
    check("cmd_error_clr", {7'd0, rx_error}, 8'd0);

    // FIFO full during three data bytes
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'($urandom), 0, 1);
      check("ovf_pulse", {7'd0, rx_overflow}, 8'd1);
      check("ovf_no_valid", {7'd0, rx_data_valid}, 8'd0);
    end
    step(0, 0, 8'h00, 0, 0);

    // Reset while a register read is in its turnaround
    step(1, 0, 8'h00, 1, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_phyreg", phyreg, 8'h00);
    dir = 1; nxt = 0; data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    dir = 0;
    rst_n = 1'b1;
    step(0, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(1, 1, 8'hA5, 0, 0);
    check("post_rst_data", rx_data, 8'hA5);
    check("post_rst_valid", {7'd0, rx_data_valid}, 8'd1);
    step(0, 0, 8'h00, 0, 0);

    // Random bus traffic
    for (int i = 0; i < 800; i++) begin
      logic d;
      d = dir;
      if ($urandom_range(5) == 0) d = ~d;
      step(d, 1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
